// File: rtl/mpc_rob.sv
// Per-channel reorder buffer: in-order tag allocation, out-of-order fills, in-order release.
// Optional same-cycle head bypass of fill data when MPC_ROB_BYPASS_EN is defined.
module mpc_rob #(
  parameter int unsigned ROB_SIZE   = 8,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned CHAN_ID_W  = 2,
  parameter int unsigned CHANNEL_ID = 0,
  localparam int unsigned ROB_W     = $clog2(ROB_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  output logic [ROB_W-1:0]  alloc_id_o,
  input  logic              fill_valid_i,
  input  logic [CHAN_ID_W-1:0] fill_chan_i,
  input  logic [ROB_W-1:0]  fill_id_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [ROB_W:0]    count_o,
  output logic              err_o
);

  localparam logic [CHAN_ID_W-1:0] ChanId = CHAN_ID_W'(CHANNEL_ID);
  localparam logic [ROB_W:0]       Full   = (ROB_W+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0] alloc_q, alloc_d;
  logic [ROB_SIZE-1:0] filled_q, filled_d;
  logic [DATA_W-1:0]   data_q [ROB_SIZE];
  logic [ROB_W-1:0]    head_q, head_d;
  logic [ROB_W-1:0]    tail_q, tail_d;
  logic [ROB_W:0]      count_q, count_d;
  logic                err_q, err_d;

  logic alloc_fire, rsp_fire, fill_legal, head_stored, bypass, data_we;

  always_comb begin
    alloc_ready_o = (count_q != Full);
    alloc_id_o    = tail_q;
    count_o       = count_q;
    err_o         = err_q;
    alloc_fire    = alloc_valid_i && alloc_ready_o;

    fill_legal  = fill_valid_i && (fill_chan_i == ChanId) &&
                  alloc_q[fill_id_i] && !filled_q[fill_id_i];
    head_stored = alloc_q[head_q] && filled_q[head_q];

`ifdef MPC_ROB_BYPASS_EN
    // A legal fill implies the target is allocated and unfilled.
    bypass      = fill_legal && (fill_id_i == head_q);
    rsp_valid_o = head_stored || bypass;
    rsp_data_o  = head_stored ? data_q[head_q] : fill_data_i;
`else
    bypass      = 1'b0;
    rsp_valid_o = head_stored;
    rsp_data_o  = data_q[head_q];
`endif

    rsp_fire = rsp_valid_o && rsp_ready_i;
    data_we  = fill_legal && !(bypass && rsp_fire);
  end

  always_comb begin
    alloc_d  = alloc_q;
    filled_d = filled_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    err_d    = err_q | (fill_valid_i && !fill_legal);

    if (alloc_fire) begin
      alloc_d[tail_q]  = 1'b1;
      filled_d[tail_q] = 1'b0;
      tail_d           = tail_q + 1'b1;
    end
    if (fill_legal) begin
      filled_d[fill_id_i] = 1'b1;
    end
    // Release last so a bypassed fill of the head leaves the entry free.
    if (rsp_fire) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      head_d           = head_q + 1'b1;
    end

    unique case ({alloc_fire, rsp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q  <= '0;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      alloc_q  <= alloc_d;
      filled_q <= filled_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Data storage is not reset; content is only visible once filled.
  always_ff @(posedge clk_i) begin
    if (data_we) begin
      data_q[fill_id_i] <= fill_data_i;
    end
  end

endmodule

// File: tb/tb_mpc_rob.sv
// Scoreboard bench for mpc_rob: expected response data is queued at allocation and
// popped when the channel handshakes a response.
module tb_mpc_rob;
  localparam int unsigned ROB_SIZE   = 8;
  localparam int unsigned ROB_W      = 3;
  localparam int unsigned DATA_W     = 128;
  localparam int unsigned CHAN_ID_W  = 2;
  localparam int unsigned CHANNEL_ID = 1;
  localparam logic [CHAN_ID_W-1:0] ChanId = CHAN_ID_W'(CHANNEL_ID);
`ifdef MPC_ROB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic alloc_valid, alloc_ready;
  logic [ROB_W-1:0] alloc_id;
  logic fill_valid;
  logic [CHAN_ID_W-1:0] fill_chan;
  logic [ROB_W-1:0] fill_id;
  logic [DATA_W-1:0] fill_data;
  logic rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ROB_W:0] count;
  logic err;

  int n_total = 0;
  int n_pass  = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mpc_rob #(
    .ROB_SIZE  (ROB_SIZE),
    .DATA_W    (DATA_W),
    .CHAN_ID_W (CHAN_ID_W),
    .CHANNEL_ID(CHANNEL_ID)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alloc_valid_i(alloc_valid),
    .alloc_ready_o(alloc_ready),
    .alloc_id_o   (alloc_id),
    .fill_valid_i (fill_valid),
    .fill_chan_i  (fill_chan),
    .fill_id_i    (fill_id),
    .fill_data_i  (fill_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .count_o      (count),
    .err_o        (err)
  );

  // Scoreboard: every response handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      logic [DATA_W-1:0] exp_d;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got %0h want no response", rsp_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (rsp_data !== exp_d) $display("FAIL sb_data: got %0h want %0h", rsp_data, exp_d);
        else n_pass++;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    fill_valid  = 1'b0;
    fill_chan   = ChanId;
    fill_id     = '0;
    fill_data   = '0;
    rsp_ready   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic alloc_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      exp_q.push_back(DATA_W'(base + i));
      cycle();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic fill(input int id, input int data);
    fill_valid = 1'b1;
    fill_id    = ROB_W'(id);
    fill_data  = DATA_W'(data);
    cycle();
    fill_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n_total++; if (alloc_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", alloc_ready); else n_pass++;
    n_total++; if (alloc_id !== 0) $display("FAIL rst_id: got %0d want 0", alloc_id); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); else n_pass++;
    n_total++; if (count !== 0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err: got %0b want 0", err); else n_pass++;
  endtask

  task automatic test_in_order();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      #1;
      n_total++; if (alloc_id !== ROB_W'(i)) $display("FAIL io_alloc_id: got %0d want %0d", alloc_id, i); else n_pass++;
      exp_q.push_back(DATA_W'('hA0 + i));
      cycle();
    end
    alloc_valid = 1'b0;
    n_total++; if (count !== 3) $display("FAIL io_count3: got %0d want 3", count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bit exp_v;
      fill_valid = 1'b1;
      fill_id    = ROB_W'(i);
      fill_data  = DATA_W'('hA0 + i);
      #1;
      exp_v = Byp || (i > 0);
      n_total++; if (rsp_valid !== exp_v) $display("FAIL io_rsp_valid: got %0b want %0b", rsp_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_total++;
        if (rsp_data !== DATA_W'(Byp ? 'hA0 + i : 'hA0 + i - 1))
          $display("FAIL io_rsp_data: got %0h want %0h", rsp_data, Byp ? 'hA0 + i : 'hA0 + i - 1);
        else n_pass++;
      end
      cycle();
    end
    fill_valid = 1'b0;
    #1;
    n_total++; if (rsp_valid !== !Byp) $display("FAIL io_tail_valid: got %0b want %0b", rsp_valid, !Byp); else n_pass++;
    cycle();
    n_total++; if (count !== 0) $display("FAIL io_count0: got %0d want 0", count); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL io_drain: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reorder();
    int order[3] = '{3, 1, 2};
    do_reset();
    rsp_ready = 1'b1;
    alloc_n(4, 0);
    foreach (order[k]) begin
      fill_valid = 1'b1;
      fill_id    = ROB_W'(order[k]);
      fill_data  = DATA_W'(order[k]);
      #1;
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL ro_early_valid: got %0b want 0", rsp_valid); else n_pass++;
      cycle();
    end
    fill_valid = 1'b1;
    fill_id    = '0;
    fill_data  = '0;
    #1;
    n_total++; if (rsp_valid !== Byp) $display("FAIL ro_head_valid: got %0b want %0b", rsp_valid, Byp); else n_pass++;
    cycle();
    fill_valid = 1'b0;
    repeat (3) cycle();
    n_total++; if (count !== (Byp ? 0 : 1)) $display("FAIL ro_b2b_count: got %0d want %0d", count, Byp ? 0 : 1); else n_pass++;
    cycle();
    n_total++; if (count !== 0) $display("FAIL ro_count0: got %0d want 0", count); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL ro_drain: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    alloc_n(8, 'h100);
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL fw_ready: got %0b want 0", alloc_ready); else n_pass++;
    n_total++; if (count !== 8) $display("FAIL fw_count8: got %0d want 8", count); else n_pass++;
    for (int i = 0; i < 8; i++) fill(i, 'h100 + i);
    alloc_valid = 1'b1;
    rsp_ready   = 1'b1;
    #1;
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL fw_no_grant: got %0b want 0", alloc_ready); else n_pass++;
    cycle();
    rsp_ready = 1'b0;
    #1;
    n_total++; if (alloc_ready !== 1'b1) $display("FAIL fw_regrant: got %0b want 1", alloc_ready); else n_pass++;
    n_total++; if (alloc_id !== 0) $display("FAIL fw_wrap_id: got %0d want 0", alloc_id); else n_pass++;
    exp_q.push_back(DATA_W'('h200));
    cycle();
    alloc_valid = 1'b0;
    n_total++; if (count !== 8) $display("FAIL fw_count_refill: got %0d want 8", count); else n_pass++;
    rsp_ready = 1'b1;
    fill(0, 'h200);
    repeat (9) cycle();
    n_total++; if (count !== 0) $display("FAIL fw_count0: got %0d want 0", count); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL fw_drain: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    alloc_n(3, 'h20);
    n_total++; if (err !== 1'b0) $display("FAIL er_clean: got %0b want 0", err); else n_pass++;
    fill_chan = 2'd2;
    fill(0, 'hEE);
    fill_chan = ChanId;
    n_total++; if (err !== 1'b1) $display("FAIL er_chan: got %0b want 1", err); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL er_chan_nofill: got %0b want 0", rsp_valid); else n_pass++;
    fill(2, 'h22);
    fill(2, 'h33);
    n_total++; if (err !== 1'b1) $display("FAIL er_double: got %0b want 1", err); else n_pass++;
    rsp_ready = 1'b1;
    fill(0, 'h20);
    fill(1, 'h21);
    repeat (3) cycle();
    n_total++; if (exp_q.size() != 0) $display("FAIL er_drain: got %0d want 0", exp_q.size()); else n_pass++;
    do_reset();
    fill(5, 'h55);
    n_total++; if (err !== 1'b1) $display("FAIL er_unalloc: got %0b want 1", err); else n_pass++;
    do_reset();
    alloc_valid = 1'b1;
    fill_valid  = 1'b1;
    fill_id     = '0;
    cycle();
    idle_inputs();
    n_total++; if (err !== 1'b1) $display("FAIL er_tail_race: got %0b want 1", err); else n_pass++;
    n_total++; if (count !== 1) $display("FAIL er_tail_count: got %0d want 1", count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(5, 'h40);
    fill(0, 'h40);
    fill(1, 'h41);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL rm_pre_valid: got %0b want 1", rsp_valid); else n_pass++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    n_total++; if (count !== 0) $display("FAIL rm_count: got %0d want 0", count); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rm_valid: got %0b want 0", rsp_valid); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rm_err: got %0b want 0", err); else n_pass++;
    n_total++; if (alloc_id !== 0) $display("FAIL rm_id: got %0d want 0", alloc_id); else n_pass++;
    fill(2, 'h42);
    n_total++; if (err !== 1'b1) $display("FAIL rm_stale_fill: got %0b want 1", err); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_n(1, 'h55);
    rsp_ready  = 1'b1;
    fill_valid = 1'b1;
    fill_id    = '0;
    fill_data  = DATA_W'('h55);
    #1;
    n_total++; if (rsp_valid !== Byp) $display("FAIL bp_same_cycle: got %0b want %0b", rsp_valid, Byp); else n_pass++;
`ifdef MPC_ROB_BYPASS_EN
    n_total++; if (rsp_data !== DATA_W'('h55)) $display("FAIL bp_data: got %0h want 55", rsp_data); else n_pass++;
`endif
    cycle();
    fill_valid = 1'b0;
    #1;
    n_total++; if (rsp_valid !== !Byp) $display("FAIL bp_next_cycle: got %0b want %0b", rsp_valid, !Byp); else n_pass++;
    cycle();
    n_total++; if (count !== 0) $display("FAIL bp_count0: got %0d want 0", count); else n_pass++;
    alloc_n(1, 'h66);
    rsp_ready = 1'b0;
    fill(1, 'h66);
    for (int i = 0; i < 2; i++) begin
      n_total++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid: got %0b want 1", rsp_valid); else n_pass++;
      n_total++; if (rsp_data !== DATA_W'('h66)) $display("FAIL bp_hold_data: got %0h want 66", rsp_data); else n_pass++;
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    n_total++; if (count !== 0) $display("FAIL bp_hold_count: got %0d want 0", count); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reorder();
    test_full_wrap();
    test_errors();
    test_reset_mid();
    test_bypass();
    idle_inputs();
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
